// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M/RV64M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} md_state_t;

    function automatic logic is_div(input md_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_a(input md_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input md_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_signadj.sv
// Two-channel conditional two's-complement negate: absolute values going in, sign fixup coming out.
module muldiv_signadj #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         negX,
    input  logic         negY,
    output logic [W-1:0] xOut,
    output logic [W-1:0] yOut
);

    assign xOut = negX ? -x : x;
    assign yOut = negY ? -y : y;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle,
// sharing a single 2*XLEN accumulator; stalls the front of the pipe while working.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNTW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t         state;
    md_op_t            opR;
    logic [4:0]        rdR;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;
    logic [CNTW-1:0]   cnt;
    logic              negQ;
    logic              negR;

    md_op_t            opIn;
    logic              isDivIn;
    logic              aNeg;
    logic              bNeg;
    logic              bZero;
    logic              special;
    logic [XLEN-1:0]   aAbs;
    logic [XLEN-1:0]   bAbs;
    logic [2*XLEN-1:0] specAcc;

    logic [XLEN:0]     mulSum;
    logic [XLEN:0]     divTrial;
    logic [XLEN:0]     divDiff;

    logic [2*XLEN-1:0] prodIn;
    logic [2*XLEN-1:0] prodAdj;
    logic [2*XLEN-1:0] remAdj;
    logic [XLEN-1:0]   fixRes;
    logic              unusedRemHi;

    // Launch-side decode
    assign opIn    = md_op_t'(op);
    assign isDivIn = is_div(opIn);
    assign aNeg    = is_signed_a(opIn) & a[XLEN-1];
    assign bNeg    = is_signed_b(opIn) & b[XLEN-1];
    assign bZero   = (b == '0);
    assign special = isDivIn & (bZero | (is_signed_b(opIn) & (a == MIN_NEG) & (b == '1)));
    // Special results are preloaded as {remainder, quotient} so FIXUP selects them like any division
    assign specAcc = bZero ? {a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, a};

    muldiv_signadj #(.W(XLEN)) inAdj (
        .x    (a),
        .y    (b),
        .negX (aNeg),
        .negY (bNeg),
        .xOut (aAbs),
        .yOut (bAbs)
    );

    // Iteration datapath
    assign mulSum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    assign divTrial = acc[2*XLEN-1:XLEN-1];
    assign divDiff  = divTrial - {1'b0, opnd};

    // Fixup datapath
    assign prodIn = is_div(opR) ? {{XLEN{1'b0}}, acc[XLEN-1:0]} : acc;

    muldiv_signadj #(.W(2*XLEN)) outAdj (
        .x    (prodIn),
        .y    ({{XLEN{1'b0}}, acc[2*XLEN-1:XLEN]}),
        .negX (negQ),
        .negY (negR),
        .xOut (prodAdj),
        .yOut (remAdj)
    );

    assign unusedRemHi = ^remAdj[2*XLEN-1:XLEN];

    always_comb begin
        fixRes = prodAdj[XLEN-1:0];
        case (opR)
            OP_MULH, OP_MULHSU, OP_MULHU: fixRes = prodAdj[2*XLEN-1:XLEN];
            OP_REM, OP_REMU:              fixRes = remAdj[XLEN-1:0];
            default:                      fixRes = prodAdj[XLEN-1:0];
        endcase
    end

    assign stall_req = (start & ~flush & ((state == IDLE) | (state == DONE))) | busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            opR    <= OP_MUL;
            rdR    <= '0;
            opnd   <= '0;
            acc    <= '0;
            cnt    <= '0;
            negQ   <= 1'b0;
            negR   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        opR  <= opIn;
                        rdR  <= rd_in;
                        opnd <= isDivIn ? bAbs : aAbs;
                        acc  <= special ? specAcc
                                        : {{XLEN{1'b0}}, (isDivIn ? aAbs : bAbs)};
                        negQ <= ~special & (aNeg ^ bNeg);
                        negR <= ~special & aNeg;
                        cnt  <= CNTW'(XLEN - 1);
                        busy <= 1'b1;
                        state <= special ? FIXUP : CALC;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (is_div(opR)) begin
                        if (!divDiff[XLEN])
                            acc <= {divDiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                        else
                            acc <= {divTrial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
                    end else begin
                        if (acc[0])
                            acc <= {mulSum, acc[XLEN-1:1]};
                        else
                            acc <= {1'b0, acc[2*XLEN-1:1]};
                    end
                    if (cnt == '0)
                        state <= FIXUP;
                    else
                        cnt <= cnt - CNTW'(1);
                end
                FIXUP: begin
                    result <= fixRes;
                    rd_out <= rdR;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN=32): directed ops with hand-computed results.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        string       name;
    } exp_t;

    exp_t expQ[$];

    logic [31:0] lastRes;
    logic [4:0]  lastRd;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .flush     (flush),
        .op        (op),
        .a         (a),
        .b         (b),
        .rd_in     (rd_in),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes one expected response
    always @(negedge clk) begin
        exp_t e;
        if (reset && done) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got result %0h rd %0d expected no done", result, rd_out);
            end else begin
                e = expQ.pop_front();
                check({e.name, "_result"}, 64'(result), 64'(e.res));
                check({e.name, "_rd"}, 64'(rd_out), 64'(e.rd));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the done cycle
    task automatic runOp(input md_op_t o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] r, input logic [31:0] exp, input int expEdges,
                         input string name);
        int   edges;
        logic stallOk;
        op = o; a = x; b = y; rd_in = r; start = 1'b1; flush = 1'b0;
        #1;
        stallOk = stall_req;
        expQ.push_back('{exp, r, name});
        @(posedge clk);
        edges = 1;
        #1 start = 1'b0;
        while (!done && edges < 100) begin
            if (!stall_req) stallOk = 1'b0;
            @(posedge clk);
            edges++;
            #1;
        end
        check({name, "_latency"}, 64'(edges), 64'(expEdges));
        check({name, "_stall"}, 64'(stallOk), 64'(1'b1));
        lastRes = exp;
        lastRd  = r;
    endtask

    task automatic launch(input md_op_t o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] r);
        op = o; a = x; b = y; rd_in = r; start = 1'b1; flush = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; rd_in = '0;
        lastRes = '0; lastRd = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_result", 64'(result), 64'(0));
        check("reset_rd", 64'(rd_out), 64'(0));
        check("reset_stall", 64'(stall_req), 64'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;

        runOp(OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34, "mul");
        runOp(OP_MULH,   32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 34, "mulh");
        runOp(OP_MULHU,  32'h80000000, 32'h80000000, 5'd7,  32'h40000000, 34, "mulhu");
        runOp(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 34, "mulhsu");
        runOp(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'hFFFFFFFE, 34, "mulhu_max");
        runOp(OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'h00000001, 34, "mul_neg");
        runOp(OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFD, 34, "div");
        runOp(OP_REM,    32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFF, 34, "rem");
        runOp(OP_DIV,    32'd7,        32'hFFFFFFFE, 5'd13, 32'hFFFFFFFD, 34, "div_negb");
        runOp(OP_REM,    32'd7,        32'hFFFFFFFE, 5'd14, 32'h00000001, 34, "rem_negb");
        runOp(OP_DIVU,   32'd100,      32'd7,        5'd15, 32'd14,       34, "divu");
        runOp(OP_REMU,   32'd100,      32'd7,        5'd16, 32'd2,        34, "remu");
        runOp(OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0,        34, "divu_big");
        runOp(OP_REMU,   32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 34, "remu_big");
        runOp(OP_DIV,    32'd5,        32'd0,        5'd19, 32'hFFFFFFFF, 2,  "div_by0");
        runOp(OP_REMU,   32'd5,        32'd0,        5'd20, 32'd5,        2,  "remu_by0");
        runOp(OP_DIVU,   32'd5,        32'd0,        5'd21, 32'hFFFFFFFF, 2,  "divu_by0");
        runOp(OP_REM,    32'hFFFFFFFB, 32'd0,        5'd22, 32'hFFFFFFFB, 2,  "rem_by0");
        runOp(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd23, 32'h80000000, 2,  "div_ovf");
        runOp(OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd24, 32'd0,        2,  "rem_ovf");

        // Done must be a single-cycle pulse when no new op follows
        @(posedge clk);
        #1;
        check("done_pulse_width", 64'(done), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));

        // Flush at edge 10 of a DIVU
        launch(OP_DIVU, 32'd100, 32'd7, 5'd25);
        repeat (8) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_done", 64'(done), 64'(0));
        check("flush_result", 64'(result), 64'(lastRes));
        check("flush_rd", 64'(rd_out), 64'(lastRd));
        check("flush_stall", 64'(stall_req), 64'(0));
        flush = 1'b0;
        runOp(OP_MUL, 32'd3, 32'd4, 5'd26, 32'd12, 34, "mul_after_flush");

        // Back-to-back issue from the DONE cycle
        runOp(OP_MULHU, 32'h00010000, 32'h00010000, 5'd27, 32'd1, 34, "b2b_first");
        runOp(OP_MUL,   32'd9,        32'd9,        5'd28, 32'd81, 34, "b2b_second");

        // Asynchronous reset at edge 20 of an in-flight op
        @(posedge clk);
        #1;
        launch(OP_DIV, 32'd1000, 32'd3, 5'd29);
        repeat (18) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_done", 64'(done), 64'(0));
        check("midreset_result", 64'(result), 64'(0));
        check("midreset_rd", 64'(rd_out), 64'(0));
        check("midreset_stall", 64'(stall_req), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        runOp(OP_MUL, 32'd6, 32'd7, 5'd30, 32'd42, 34, "mul_after_reset");

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 64'(expQ.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
